// File: rtl/platform_collision_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : platform_collision_scan_if
// Purpose  : Bundles the configuration, scan-request and result signals of
//            the platform collision scanner.
//            master : level loader / player physics side (drives cfg + start)
//            slave  : collision scanner side (drives busy/done/results)
// Revision : 1.0  initial release
// ============================================================================
interface platform_collision_scan_if #(
    parameter int COORD_W  = 10,
    parameter int NUM_PLAT = 16
);
    localparam int IDX_W = $clog2(NUM_PLAT);

    // table load
    logic               cfg_we;
    logic               cfg_clear;
    logic [IDX_W-1:0]   cfg_idx;
    logic [COORD_W-1:0] cfg_x_min;
    logic [COORD_W-1:0] cfg_x_max;
    logic [COORD_W-1:0] cfg_y_top;
    logic [COORD_W-1:0] cfg_y_bot;
    // scan request
    logic               start;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;
    // status / results
    logic               busy;
    logic               done;
    logic               on_ground;
    logic [COORD_W-1:0] support_y;
    logic [IDX_W-1:0]   support_idx;
    logic               hit_ceiling;
    logic               hit_left_wall;
    logic               hit_right_wall;

    modport master (
        output cfg_we, cfg_clear, cfg_idx, cfg_x_min, cfg_x_max, cfg_y_top, cfg_y_bot,
        output start, player_x, player_y,
        input  busy, done, on_ground, support_y, support_idx,
        input  hit_ceiling, hit_left_wall, hit_right_wall
    );

    modport slave (
        input  cfg_we, cfg_clear, cfg_idx, cfg_x_min, cfg_x_max, cfg_y_top, cfg_y_bot,
        input  start, player_x, player_y,
        output busy, done, on_ground, support_y, support_idx,
        output hit_ceiling, hit_left_wall, hit_right_wall
    );
endinterface
`default_nettype wire

// File: rtl/platform_collision_scan.sv
`default_nettype none
// ============================================================================
// Module   : platform_collision_scan
// Purpose  : Table-driven player-vs-platform collision engine. A writable
//            table of NUM_PLAT rectangles is scanned one entry per clock
//            against a sampled player box; ground support (with chosen
//            platform index/top), ceiling and wall contacts are reported
//            with a one-cycle done pulse.
// Ports    : clk    - system clock
//            reset  - synchronous, active-high
//            bus    - platform_collision_scan_if.slave (cfg, start, player
//                     position in; busy, done and result flags out)
// Revision : 1.0  initial release
// ============================================================================
module platform_collision_scan #(
    parameter int COORD_W     = 10,
    parameter int NUM_PLAT    = 16,
    parameter int PLAYER_W    = 16,
    parameter int PLAYER_H    = 16,
    parameter int LANDING_TOL = 8,
    parameter int CEILING_TOL = 12,
    parameter int WALL_TOL    = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    platform_collision_scan_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_PLAT);
    localparam int W1    = COORD_W + 1;

    // Widened constants: sums are formed one bit wider so they never wrap.
    localparam logic [W1-1:0]      c_player_h   = W1'(PLAYER_H);
    localparam logic [W1-1:0]      c_player_wm1 = W1'(PLAYER_W - 1);
    localparam logic [W1-1:0]      c_land_tol   = W1'(LANDING_TOL);
    localparam logic [W1-1:0]      c_wall_tol_w = W1'(WALL_TOL);
    localparam logic [COORD_W-1:0] c_ceil_tol   = COORD_W'(CEILING_TOL);
    localparam logic [COORD_W-1:0] c_wall_tol   = COORD_W'(WALL_TOL);
    localparam logic [IDX_W-1:0]   c_last_idx   = IDX_W'(NUM_PLAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy;
    logic   w_done;
    logic   w_accept;
    logic   w_last;

    // ---------------------------------------------------------------- table
    logic [COORD_W-1:0] r_x_min [NUM_PLAT];
    logic [COORD_W-1:0] r_x_max [NUM_PLAT];
    logic [COORD_W-1:0] r_y_top [NUM_PLAT];
    logic [COORD_W-1:0] r_y_bot [NUM_PLAT];
    logic [NUM_PLAT-1:0] r_valid;

    // Loads are only honoured while idle so a scan sees a stable table.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.cfg_clear) begin
                r_valid <= '0;
            end else if (bus.cfg_we) begin
                r_valid[bus.cfg_idx] <= 1'b1;
                r_x_min[bus.cfg_idx] <= bus.cfg_x_min;
                r_x_max[bus.cfg_idx] <= bus.cfg_x_max;
                r_y_top[bus.cfg_idx] <= bus.cfg_y_top;
                r_y_bot[bus.cfg_idx] <= bus.cfg_y_bot;
            end
        end
    end

    // ------------------------------------------------------------- registers
    logic [COORD_W-1:0] r_px, r_py;
    logic [IDX_W-1:0]   r_idx;
    logic               r_acc_found, r_acc_ceil, r_acc_left, r_acc_right;
    logic [COORD_W-1:0] r_acc_y;
    logic [IDX_W-1:0]   r_acc_idx;
    logic               r_on_ground, r_ceil, r_left, r_right;
    logic [COORD_W-1:0] r_support_y;
    logic [IDX_W-1:0]   r_support_idx;

    // ----------------------------------------------------- entry evaluation
    logic [COORD_W-1:0] w_ex_min, w_ex_max, w_ey_top, w_ey_bot;
    logic               w_valid;
    logic [W1-1:0]      w_feet, w_right, w_top_tol, w_xmin_tol;
    logic [COORD_W-1:0] w_ybot_lo, w_xmax_lo;
    logic               w_xov, w_yov, w_sup, w_ceil, w_lwall, w_rwall, w_take;
    logic               w_n_found, w_n_ceil, w_n_left, w_n_right;
    logic [COORD_W-1:0] w_n_y;
    logic [IDX_W-1:0]   w_n_idx;

    assign w_ex_min   = r_x_min[r_idx];
    assign w_ex_max   = r_x_max[r_idx];
    assign w_ey_top   = r_y_top[r_idx];
    assign w_ey_bot   = r_y_bot[r_idx];
    assign w_valid    = r_valid[r_idx];

    assign w_feet     = {1'b0, r_py} + c_player_h;
    assign w_right    = {1'b0, r_px} + c_player_wm1;
    assign w_top_tol  = {1'b0, w_ey_top} + c_land_tol;
    assign w_xmin_tol = {1'b0, w_ex_min} + c_wall_tol_w;
    // Lower edges of the ceiling and left-wall bands clamp at zero.
    assign w_ybot_lo  = (w_ey_bot > c_ceil_tol) ? (w_ey_bot - c_ceil_tol) : '0;
    assign w_xmax_lo  = (w_ex_max > c_wall_tol) ? (w_ex_max - c_wall_tol) : '0;

    assign w_xov   = w_valid && (w_right >= {1'b0, w_ex_min}) && (r_px <= w_ex_max);
    assign w_yov   = w_valid && (w_feet >= {1'b0, w_ey_top}) && (r_py <= w_ey_bot);
    assign w_sup   = w_xov && (w_feet >= {1'b0, w_ey_top}) && (w_feet <= w_top_tol);
    assign w_ceil  = w_xov && w_yov && (r_py >= w_ybot_lo) && (r_py <= w_ey_bot);
    assign w_lwall = w_yov && (r_px >= w_xmax_lo) && (r_px <= w_ex_max);
    assign w_rwall = w_yov && (w_right >= {1'b0, w_ex_min}) && (w_right <= w_xmin_tol);

    // Entries arrive in ascending index order, so a strict '>' keeps the
    // lowest index among equal platform tops.
    assign w_take    = w_sup && (!r_acc_found || (w_ey_top > r_acc_y));
    assign w_n_found = r_acc_found | w_sup;
    assign w_n_y     = w_take ? w_ey_top : r_acc_y;
    assign w_n_idx   = w_take ? r_idx : r_acc_idx;
    assign w_n_ceil  = r_acc_ceil  | w_ceil;
    assign w_n_left  = r_acc_left  | w_lwall;
    assign w_n_right = r_acc_right | w_rwall;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_busy = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_px          <= '0;
            r_py          <= '0;
            r_idx         <= '0;
            r_acc_found   <= 1'b0;
            r_acc_y       <= '0;
            r_acc_idx     <= '0;
            r_acc_ceil    <= 1'b0;
            r_acc_left    <= 1'b0;
            r_acc_right   <= 1'b0;
            r_on_ground   <= 1'b0;
            r_support_y   <= '0;
            r_support_idx <= '0;
            r_ceil        <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
        end else if (w_accept) begin
            r_px        <= bus.player_x;
            r_py        <= bus.player_y;
            r_idx       <= '0;
            r_acc_found <= 1'b0;
            r_acc_y     <= '0;
            r_acc_idx   <= '0;
            r_acc_ceil  <= 1'b0;
            r_acc_left  <= 1'b0;
            r_acc_right <= 1'b0;
        end else if (w_busy) begin
            r_idx       <= r_idx + 1'b1;
            r_acc_found <= w_n_found;
            r_acc_y     <= w_n_y;
            r_acc_idx   <= w_n_idx;
            r_acc_ceil  <= w_n_ceil;
            r_acc_left  <= w_n_left;
            r_acc_right <= w_n_right;
            // Results publish on the final entry so they are valid with done.
            if (w_last) begin
                r_on_ground   <= w_n_found;
                r_support_y   <= w_n_y;
                r_support_idx <= w_n_idx;
                r_ceil        <= w_n_ceil;
                r_left        <= w_n_left;
                r_right       <= w_n_right;
            end
        end
    end

    assign bus.busy           = w_busy;
    assign bus.done           = w_done;
    assign bus.on_ground      = r_on_ground;
    assign bus.support_y      = r_support_y;
    assign bus.support_idx    = r_support_idx;
    assign bus.hit_ceiling    = r_ceil;
    assign bus.hit_left_wall  = r_left;
    assign bus.hit_right_wall = r_right;

endmodule
`default_nettype wire
